frame_scanout: RTL
==================

// Module: frame_scanout
// PURPOSE
//  Read-side end of the pixel frame buffer: generates raster timing, issues sequential {y,x}
//  read addresses to the Ram read port and emits RGB555 with hsync/vsync/de for the display.
//  Consumes the buffer the Pixel/Counter write path fills. Scans whole frames only, starting
//  at a frame boundary once fb_valid is high.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   hsync width (pixels)
//  H_BP       48   horizontal back porch (pixels)
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vsync width (lines)
//  V_BP       33   vertical back porch (lines)
//  RD_LATENCY 1    Ram read latency in clk cycles (1..4)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-low
//  en           in   1   pixel tick; timing advances one pixel per clk with en=1
//  fb_valid     in   1   frame buffer holds a complete frame; sampled only at frame boundaries
//  rd_en        out  1   Ram read enable
//  rd_addr      out  20  Ram read address {y[9:0],x[9:0]}
//  rd_data      in   15  Ram read data, valid RD_LATENCY clks after rd_en
//  rgb_out      out  15  pixel colour, 0 when blanked
//  de           out  1   data enable (active pixel)
//  hsync        out  1   horizontal sync, active-low
//  vsync        out  1   vertical sync, active-low
//  frame_start  out  1   one-clk pulse on tick for (x=0,y=0), undelayed
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, h=v=0, rd_en=0, rd_addr=0, rgb_out=0, de=0, hsync=1,
//   vsync=1, frame_start=0, delay line cleared.
//  H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). h,v are 10-bit.
//  FSM: IDLE -> SCAN on clk with en=1 and fb_valid=1; that same tick is pixel (0,0).
//   SCAN: each en tick, h++; at h=H_TOTAL-1, h->0 and v++; at v=V_TOTAL-1 and h=H_TOTAL-1,
//   v->0 and: fb_valid=1 -> stay SCAN (next tick is (0,0)); fb_valid=0 -> IDLE.
//   fb_valid deassert mid-frame has no effect until the frame ends.
//  Read issue (combinational from current h,v and state): rd_en=SCAN & en & h<H_ACTIVE &
//   v<V_ACTIVE; rd_addr={v,h} when rd_en, else holds last issued value.
//  Timing per tick: active=h<H_ACTIVE & v<V_ACTIVE; hs_n=0 iff H_ACTIVE+H_FP<=h<
//   H_ACTIVE+H_FP+H_SYNC; vs_n=0 iff V_ACTIVE+V_FP<=v<V_ACTIVE+V_FP+V_SYNC.
//  Delay line: {tick,active,hs_n,vs_n} shifts every clk through RD_LATENCY stages, tick=en&SCAN.
//   When the delayed tick emerges, registered outputs update in the same clk as rd_data is
//   valid: de<=active, hsync<=hs_n, vsync<=vs_n, rgb_out<=active?rd_data:0. Otherwise hold.
//   Net latency: outputs change RD_LATENCY+1 clks after the en tick that produced them.
//  en=0: h,v,FSM frozen; in-flight delay-line entries still drain and update outputs.
//  IDLE: no new ticks; outputs hold after drain (final drained pixel is blanking -> rgb 0, syncs 1).
//  frame_start=1 for exactly the clk of the (0,0) tick (IDLE->SCAN entry or frame wrap).
//  Reset mid-frame: immediate return to reset values; no partial pixels emitted afterwards.
// TESTING
//  T1 reset: hold rst=0, toggle en/fb_valid -> all outputs at reset values, hsync=vsync=1.
//  T2 start: en=1, fb_valid 0->1 at cycle N -> cycle N: rd_en=1, rd_addr=0, frame_start=1;
//   Ram returns 0x7C00 -> cycle N+2: rgb_out=0x7C00, de=1 (RD_LATENCY=1).
//  T3 line: after 640 active ticks rd_en=0, de falls 2 clks later; hsync low for exactly 96 ticks
//   beginning at h=656; tick 800 issues rd_addr={10'd1,10'd0}=0x00400.
//  T4 frame: vsync low for 2 lines from v=490; after 525x800 ticks with fb_valid=1 frame_start
//   pulses again and rd_addr=0; with fb_valid=0 FSM enters IDLE, rd_en stays 0.
//  T5 stalls: en pseudo-random 50% -> rgb_out sequence equals Ram data for addresses in raster
//   order, no duplicates/drops; outputs hold while en=0.
//  T6 reset mid-frame at v=100,h=300 -> outputs at reset values next clk; restart scans from (0,0).

Source files
------------

// File: rtl/frame_scanout.sv
// frame_scanout: raster timing generator that reads the frame buffer in {y,x} order
// and emits RGB555 with hsync/vsync/de aligned to the Ram read latency.
module frame_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        fb_valid,
  output logic        rd_en,
  output logic [19:0] rd_addr,
  input  logic [14:0] rd_data,
  output logic [14:0] rgb_out,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = 4 * RD_LATENCY;
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_nx;
  logic [9:0] h, v;
  logic [19:0] addr_q;
  logic tick, active, hs_n, vs_n, eol, eof;
  logic [DW-1:0] dl;
  logic [3:0] dl_out;
  // In IDLE with fb_valid high, this very tick is already pixel (0,0).
  assign tick = rst && en && (state == SCAN || fb_valid);
  assign eol = h == 10'(H_TOTAL - 1);
  assign eof = eol && v == 10'(V_TOTAL - 1);
  assign active = h < 10'(H_ACTIVE) && v < 10'(V_ACTIVE);
  assign hs_n = !(h >= 10'(H_ACTIVE + H_FP) && h < 10'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_n = !(v >= 10'(V_ACTIVE + V_FP) && v < 10'(V_ACTIVE + V_FP + V_SYNC));
  assign rd_en = tick && active;
  assign rd_addr = rd_en ? {v, h} : addr_q;
  assign frame_start = tick && h == '0 && v == '0;
  assign dl_out = dl[DW-1 -: 4];
  always_comb state_nx = !tick ? state : (eof && !fb_valid) ? IDLE : SCAN;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      h <= '0;
      v <= '0;
      addr_q <= '0;
    end else begin
      addr_q <= rd_addr;
      if (tick) begin
        h <= eol ? '0 : h + 10'd1;
        v <= eof ? '0 : eol ? v + 10'd1 : v;
      end
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dl <= '0;
      rgb_out <= '0;
      de <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      dl <= DW'({dl, tick, active, hs_n, vs_n});
      if (dl_out[3]) begin
        de <= dl_out[2];
        hsync <= dl_out[1];
        vsync <= dl_out[0];
        rgb_out <= dl_out[2] ? rd_data : '0;
      end
    end
endmodule
